// File: rtl/mem_port_arbiter.sv
// Round-robin data-memory port arbiter with per-core lock.
// Synchronous memory read; read-valid follows a read grant by one cycle.
module mem_port_arbiter #(
  parameter int CORE_COUNT = 4,
  parameter int REG_WIDTH  = 12,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic [CORE_COUNT-1:0]            core_req,
  input  logic [CORE_COUNT-1:0]            core_wrEn,
  input  logic [CORE_COUNT-1:0]            core_lock,
  input  logic [ADDR_WIDTH*CORE_COUNT-1:0] core_addr,
  input  logic [REG_WIDTH*CORE_COUNT-1:0]  core_wrData,
  output logic [CORE_COUNT-1:0]            core_gnt,
  output logic [CORE_COUNT-1:0]            core_rdValid,
  output logic [REG_WIDTH-1:0]             core_rdData,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [REG_WIDTH-1:0]             mem_wrData,
  output logic                             mem_wrEn,
  input  logic [REG_WIDTH-1:0]             mem_rdData
);

  localparam int IW = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;

  typedef enum logic {
    OPEN   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                state;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         owner;
  logic [CORE_COUNT-1:0] rv_q;
  logic                  hit;
  logic [IW-1:0]         win;
  logic [CORE_COUNT-1:0] gnt;

  function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
    if (int'(i) == CORE_COUNT - 1) return '0;
    return i + 1'b1;
  endfunction

  // Pick the winner: owner only when locked, else first requester from ptr.
  always_comb begin
    int idx;
    hit = 1'b0;
    win = '0;
    idx = 0;
    if (rstN) begin
      if (state == LOCKED) begin
        hit = core_req[owner];
        win = owner;
      end else begin
        for (int k = CORE_COUNT - 1; k >= 0; k--) begin
          idx = (int'(ptr) + k) % CORE_COUNT;
          if (core_req[IW'(idx)]) begin
            hit = 1'b1;
            win = IW'(idx);
          end
        end
      end
    end
  end

  // Steer the winning core's request onto the memory port.
  always_comb begin
    gnt        = '0;
    mem_wrEn   = 1'b0;
    mem_addr   = '0;
    mem_wrData = '0;
    if (hit) begin
      gnt[win]   = 1'b1;
      mem_wrEn   = core_wrEn[win];
      mem_addr   = core_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
      mem_wrData = core_wrData[int'(win)*REG_WIDTH +: REG_WIDTH];
    end
  end

  assign core_gnt     = gnt;
  assign core_rdValid = rstN ? rv_q : '0;
  assign core_rdData  = mem_rdData;

  // Arbitration state, lock ownership and read-valid pipeline.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state <= OPEN;
      ptr   <= '0;
      owner <= '0;
      rv_q  <= '0;
    end else begin
      rv_q <= (hit && !core_wrEn[win]) ? gnt : '0;
      unique case (state)
        OPEN: begin
          if (hit) begin
            ptr <= inc(win);
            if (core_lock[win]) begin
              state <= LOCKED;
              owner <= win;
            end
          end
        end
        LOCKED: begin
          if (!core_lock[owner]) begin
            state <= OPEN;
            ptr   <= inc(owner);
          end
        end
        default: state <= OPEN;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic
// against a behavioural arbiter/memory model.
module tb_mem_port_arbiter;
  localparam int N  = 4;
  localparam int DW = 12;
  localparam int AW = 12;

  logic            clk = 1'b0;
  logic            rstN;
  logic [N-1:0]    req, wr, lk;
  logic [AW*N-1:0] addr;
  logic [DW*N-1:0] wd;
  logic [N-1:0]    gnt, rv;
  logic [DW-1:0]   rdata, mrd, mwd;
  logic [AW-1:0]   maddr;
  logic            mwen;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .CORE_COUNT(N), .REG_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rstN(rstN),
    .core_req(req), .core_wrEn(wr), .core_lock(lk),
    .core_addr(addr), .core_wrData(wd),
    .core_gnt(gnt), .core_rdValid(rv), .core_rdData(rdata),
    .mem_addr(maddr), .mem_wrData(mwd), .mem_wrEn(mwen),
    .mem_rdData(mrd)
  );

  logic [DW-1:0] envmem [4096];
  always_ff @(posedge clk) begin
    if (mwen) envmem[maddr] <= mwd;
    mrd <= envmem[maddr];
  end

  logic [DW-1:0] refmem [4096];
  bit            known  [4096];
  int            m_ptr, m_owner, mw;
  bit            m_locked, m_rdk;
  logic [N-1:0]  m_rv;
  logic [DW-1:0] m_rd;
  int            waitc [N];
  logic [N-1:0]  obs_gnt, obs_rv;
  logic          obs_wen;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_wd, obs_rd;
  int            nchk = 0;
  int            npass = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int pick();
    if (!rstN) return -1;
    if (m_locked) return req[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic cycle();
    logic [31:0] eg, ew, ea, ed;
    @(negedge clk);
    mw = pick();
    obs_gnt = gnt; obs_rv = rv; obs_wen = mwen;
    obs_addr = maddr; obs_wd = mwd; obs_rd = rdata;
    eg = 0; ew = 0; ea = 0; ed = 0;
    if (mw >= 0) begin
      eg = 32'(1) << mw;
      ew = 32'(wr[mw]);
      ea = 32'(addr[AW*mw +: AW]);
      ed = 32'(wd[DW*mw +: DW]);
    end
    chk("gnt", 32'(gnt), eg);
    chk("mem_wrEn", 32'(mwen), ew);
    chk("mem_addr", 32'(maddr), ea);
    chk("mem_wrData", 32'(mwd), ed);
    chk("rdValid", 32'(rv), rstN ? 32'(m_rv) : 0);
    chk("rdPass", 32'(rdata), 32'(mrd));
    if (rstN && m_rv != 0 && m_rdk)
      chk("rdData", 32'(rdata), 32'(m_rd));
    @(posedge clk);
    if (!rstN) begin
      m_locked = 0; m_owner = 0; m_ptr = 0; m_rv = '0;
      for (int i = 0; i < N; i++) waitc[i] = 0;
    end else begin
      m_rv = '0;
      if (mw >= 0) begin
        if (wr[mw]) begin
          refmem[addr[AW*mw +: AW]] = wd[DW*mw +: DW];
          known[addr[AW*mw +: AW]] = 1;
        end else begin
          m_rv[mw] = 1'b1;
          m_rd  = refmem[addr[AW*mw +: AW]];
          m_rdk = known[addr[AW*mw +: AW]];
        end
      end
      if (!m_locked && mw >= 0) begin
        for (int i = 0; i < N; i++) begin
          if (i == mw || !req[i]) waitc[i] = 0;
          else begin
            waitc[i]++;
            chk("starve", 32'(waitc[i] <= N - 1), 1);
          end
        end
      end
      if (!m_locked) begin
        if (mw >= 0) begin
          m_ptr = (mw + 1) % N;
          if (lk[mw]) begin m_locked = 1; m_owner = mw; end
        end
      end else if (!lk[m_owner]) begin
        m_locked = 0;
        m_ptr = (m_owner + 1) % N;
      end
    end
    #1;
  endtask

  task automatic setc(int i, bit r, bit w, bit l,
                      logic [AW-1:0] a, logic [DW-1:0] d);
    req[i] = r; wr[i] = w; lk[i] = l;
    addr[AW*i +: AW] = a;
    wd[DW*i +: DW] = d;
  endtask

  task automatic do_reset();
    rstN = 0; req = '0; wr = '0; lk = '0;
    cycle();
    rstN = 1;
  endtask

  logic [N-1:0] seq [5];

  initial begin
    rstN = 0; req = '0; wr = '0; lk = '0; addr = '0; wd = '0;
    m_ptr = 0; m_owner = 0; m_locked = 0; m_rv = '0;
    m_rd = '0; m_rdk = 0; mw = -1;
    for (int i = 0; i < N; i++) waitc[i] = 0;
    for (int i = 0; i < 4096; i++) known[i] = 0;
    #1;
    do_reset();
    chk("reset gnt", 32'(obs_gnt), 0);
    chk("reset wen", 32'(obs_wen), 0);

    // all cores reading: 0,1,2,3,0 with read-valid one cycle later
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
    seq[3] = 4'b1000; seq[4] = 4'b0001;
    for (int i = 0; i < N; i++) setc(i, 1, 0, 0, AW'(i), '0);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("rr gnt", 32'(obs_gnt), 32'(seq[k]));
      if (k > 0) chk("rr rv", 32'(obs_rv), 32'(seq[k-1]));
    end
    req = '0;
    cycle();
    chk("rr rv last", 32'(obs_rv), 32'(seq[4]));

    // single write by core 2, then read it back
    do_reset();
    setc(2, 1, 1, 0, 12'h01A, 12'h5A5);
    cycle();
    chk("wr gnt", 32'(obs_gnt), 32'h4);
    chk("wr wen", 32'(obs_wen), 1);
    chk("wr addr", 32'(obs_addr), 32'h01A);
    chk("wr data", 32'(obs_wd), 32'h5A5);
    req = '0;
    cycle();
    chk("wr rv", 32'(obs_rv), 0);
    setc(2, 1, 0, 0, 12'h01A, 12'h000);
    cycle();
    req = '0;
    cycle();
    chk("rb rv", 32'(obs_rv), 32'h4);
    chk("rb data", 32'(obs_rd), 32'h5A5);

    // core 1 holds a lock for three grants
    do_reset();
    wr = '0;
    setc(0, 1, 0, 0, 12'h001, '0);
    setc(1, 1, 0, 0, 12'h002, '0);
    setc(3, 1, 0, 0, 12'h003, '0);
    cycle();
    chk("lk pre", 32'(obs_gnt), 32'h1);
    lk[1] = 1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("lk own", 32'(obs_gnt), 32'h2);
    end
    req[1] = 0; lk[1] = 0;
    cycle();
    chk("lk drop", 32'(obs_gnt), 0);
    cycle();
    chk("lk next", 32'(obs_gnt), 32'h8);

    // locked owner idle with lock held stalls others
    do_reset();
    setc(1, 1, 0, 1, 12'h004, '0);
    cycle();
    chk("idle own", 32'(obs_gnt), 32'h2);
    req[1] = 0;
    setc(0, 1, 1, 0, 12'h005, 12'h123);
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("idle gnt", 32'(obs_gnt), 0);
      chk("idle wen", 32'(obs_wen), 0);
    end
    lk[1] = 0;
    cycle();
    cycle();
    chk("idle rel", 32'(obs_gnt), 32'h1);

    // reset right after a locked read grant to core 3
    do_reset();
    setc(3, 1, 0, 1, 12'h006, '0);
    cycle();
    chk("rst grant", 32'(obs_gnt), 32'h8);
    rstN = 0;
    cycle();
    chk("rst rv", 32'(obs_rv), 0);
    chk("rst gnt", 32'(obs_gnt), 0);
    rstN = 1;
    lk = '0;
    for (int i = 0; i < N; i++) setc(i, 1, 0, 0, AW'(i), '0);
    cycle();
    chk("rst first", 32'(obs_gnt), 32'h1);
    chk("rst rv2", 32'(obs_rv), 0);

    // random traffic
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] || mw == i)
          setc(i, bit'($urandom % 2), bit'($urandom % 2), 0,
               AW'($urandom % 16), DW'($urandom));
        lk[i] = ($urandom % 5) == 0;
      end
      rstN = ($urandom % 300) != 0;
      cycle();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter CORE_COUNT, default 4, number of requesting cores (2..8).
REQ-002 SHALL have parameter REG_WIDTH, default 12, data word width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 12, data-memory address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rstN  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port core_req  input  CORE_COUNT  per-core access request, bit i = core i.
REQ-007 SHALL have port core_wrEn  input  CORE_COUNT  per-core write (1) / read (0) select.
REQ-008 SHALL have port core_lock  input  CORE_COUNT  per-core request to keep ownership after the current grant.
REQ-009 SHALL have port core_addr  input  ADDR_WIDTH*CORE_COUNT  packed addresses, core i at [ADDR_WIDTH*i +: ADDR_WIDTH].
REQ-010 SHALL have port core_wrData  input  REG_WIDTH*CORE_COUNT  packed write data, same packing.
REQ-011 SHALL have port core_gnt  output  CORE_COUNT  one-hot access-accepted indication.
REQ-012 SHALL have port core_rdValid  output  CORE_COUNT  one-hot read-data-valid strobe.
REQ-013 SHALL have port core_rdData  output  REG_WIDTH  read data broadcast to all cores.
REQ-014 SHALL have port mem_addr  output  ADDR_WIDTH  data-memory address.
REQ-015 SHALL have port mem_wrData  output  REG_WIDTH  data-memory write data.
REQ-016 SHALL have port mem_wrEn  output  1  data-memory write enable.
REQ-017 SHALL have port mem_rdData  input  REG_WIDTH  data-memory read data, valid one cycle after address (synchronous read).

Function
REQ-018 SHALL grant at most one core per cycle; core_gnt SHALL be combinational from core_req and internal state, zero-hot when no request.
REQ-019 SHALL select the winner round-robin: search starts at index ptr and wraps from CORE_COUNT-1 to 0; lowest searched index with core_req=1 wins.
REQ-020 SHALL update ptr at each clock edge with a grant to (winner+1) mod CORE_COUNT; no grant -> ptr unchanged.
REQ-021 SHALL drive mem_addr, mem_wrData from the winner's slice and mem_wrEn = winner's core_wrEn in the grant cycle; no grant -> mem_wrEn=0, mem_addr/mem_wrData=0.
REQ-022 A requester SHALL hold req, wrEn, addr, wrData stable until the edge at which its core_gnt=1; the access completes at that edge.
REQ-023 For a granted read, core_rdValid[winner] SHALL be 1 exactly in the following cycle, with core_rdData = mem_rdData; core_rdData SHALL pass mem_rdData through in all cycles.
REQ-024 For a granted write, core_rdValid SHALL remain 0.
REQ-025 State machine: OPEN (round-robin arbitration) and LOCKED (owner register holds a core index).
REQ-026 OPEN -> LOCKED at an edge where winner has core_lock=1; owner := winner.
REQ-027 In LOCKED, only the owner SHALL be eligible; other requests wait, ptr unchanged.
REQ-028 LOCKED -> OPEN at an edge where owner is granted with core_lock=0, or where owner has core_req=0 and core_lock=0; ptr := (owner+1) mod CORE_COUNT.
REQ-029 In LOCKED with owner core_req=0 and core_lock=1, SHALL issue no grant and remain LOCKED.
REQ-030 Back-to-back accesses SHALL be possible every cycle (throughput 1 access/cycle); read and write grants in consecutive cycles SHALL not interfere.
REQ-031 A requester SHALL wait at most CORE_COUNT-1 grants in OPEN before being granted.

Reset
REQ-032 While rstN=0 at an edge: ptr := 0, state := OPEN, owner := 0, core_rdValid := 0.
REQ-033 During a cycle with rstN=0, core_gnt SHALL be 0 and mem_wrEn SHALL be 0 regardless of requests.
REQ-034 Reset mid-operation SHALL discard a pending read-valid and release any lock; first arbitration after reset starts at core 0.

Verification
REQ-035 After reset, core_req=4'b1111, all reads, held -> grants in order core 0,1,2,3,0 on consecutive cycles; core_rdValid follows each grant by one cycle.
REQ-036 Only core 2 requests a write, addr=0x01A, data=0x5A5 -> same cycle core_gnt=4'b0100, mem_wrEn=1, mem_addr=0x01A, mem_wrData=0x5A5; next cycle core_rdValid=0.
REQ-037 Core 1 reads with core_lock=1 for 3 grants while cores 0,3 request -> cores 0,3 get no grant for those 3 cycles; after lock drop, core 3 granted next (ptr=2).
REQ-038 Core 1 locked, core_req[1]=0, core_lock[1]=1 for 2 cycles, core 0 requesting -> no grant, mem_wrEn=0; then lock=0 -> core 0 granted.
REQ-039 rstN=0 for one cycle immediately after a read grant to core 3 while core 3 holds a lock -> core_rdValid stays 0, state OPEN, next grant with all requesting is core 0.
REQ-040 Random req/wrEn/lock traffic over 10000 cycles -> never more than one core_gnt bit set, no starvation beyond REQ-031 in OPEN, each read's data matches a reference memory model.
